// File: rtl/hazard_controller_pkg.sv
// Shared pipeline constants: hazard FSM state encoding and MDU defaults.
package hazard_controller_pkg;

  localparam int unsigned MDU_LATENCY_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT       = 6;
  localparam int unsigned REG_W               = 5;
  localparam int unsigned STALL_W             = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hazState_t;

endpackage

// File: rtl/hazard_controller_load_use.sv
// Load-use compare between the EX-stage load and the ID-stage source registers.
module loadUseDetect
  import hazard_controller_pkg::*;
(
  input  logic             memRead,
  input  logic [REG_W-1:0] exRt,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             usesRt,
  output logic             hazard_c
);

  // A load into $zero never creates a dependency; Rt only matters if it is read.
  assign hazard_c = memRead && (exRt != '0) &&
                    ((exRt == idRs) || (usesRt && (exRt == idRt)));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: branch flush, load-use stall and multi-cycle MDU stall.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               IDEX_MemRead,
  input  logic               IDEX_MDUOp,
  input  logic [REG_W-1:0]   IDEX_RegisterRt,
  input  logic [REG_W-1:0]   IFID_RegisterRs,
  input  logic [REG_W-1:0]   IFID_RegisterRt,
  input  logic               IFID_UsesRt,
  input  logic               Branch_Taken,
  output logic               PC_Write,
  output logic               IFID_Write,
  output logic               IDEX_Write,
  output logic               IFID_Flush,
  output logic               IDEX_Flush,
  output logic               IDEX_Bubble,
  output logic               EXMEM_Bubble,
  output logic               MDU_Start,
  output logic               MDU_Busy,
  output logic [STALL_W-1:0] Stall_Count
);

  hazState_t          state;
  hazState_t          nextState;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   nextCnt;
  logic [STALL_W-1:0] stallCount;
  logic               loadUse;

  loadUseDetect uLoadUse (
    .memRead  (IDEX_MemRead),
    .exRt     (IDEX_RegisterRt),
    .idRs     (IFID_RegisterRs),
    .idRt     (IFID_RegisterRt),
    .usesRt   (IFID_UsesRt),
    .hazard_c (loadUse)
  );

  // Next-state and stage-control decode from state, cnt and current inputs.
  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    MDU_Start    = 1'b0;
    MDU_Busy     = 1'b0;
    nextState    = state;
    nextCnt      = cnt;

    if (rst_i) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
      IDEX_Bubble  = 1'b1;
      EXMEM_Bubble = 1'b1;
      nextState    = RUN;
      nextCnt      = '0;
    end else begin
      case (state)
        RUN: begin
          if (Branch_Taken) begin
            // Wrong-path instructions are squashed, so their hazards are moot.
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
          end else if (IDEX_MDUOp) begin
            MDU_Start    = 1'b1;
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            nextState    = MDU_WAIT;
            nextCnt      = CNT_W'(MDU_LATENCY - 1);
          end else if (loadUse) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
          end
        end
        MDU_WAIT: begin
          MDU_Busy = 1'b1;
          if (cnt > CNT_W'(1)) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            nextCnt      = cnt - CNT_W'(1);
          end else begin
            // Last cycle: let the MDU result advance into MEM.
            nextState = RUN;
            nextCnt   = '0;
          end
        end
        default: begin
          nextState = RUN;
          nextCnt   = '0;
        end
      endcase
    end
  end

  // State, MDU counter and saturating stall counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RUN;
      cnt        <= '0;
      stallCount <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (!PC_Write && (stallCount != '1)) begin
        stallCount <= stallCount + STALL_W'(1);
      end
    end
  end

  assign Stall_Count = stallCount;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller with MDU_LATENCY=4.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead;
  logic        mduOp;
  logic [4:0]  exRt;
  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic        usesRt;
  logic        branch;
  logic        pcWrite, ifidWrite, idexWrite;
  logic        ifidFlush, idexFlush, idexBubble, exmemBubble;
  logic        mduStart, mduBusy;
  logic [15:0] stallCount;

  int nAsserts = 0;
  int nFail    = 0;

  hazard_controller #(.MDU_LATENCY(4), .CNT_W(6)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .IDEX_MemRead    (memRead),
    .IDEX_MDUOp      (mduOp),
    .IDEX_RegisterRt (exRt),
    .IFID_RegisterRs (idRs),
    .IFID_RegisterRt (idRt),
    .IFID_UsesRt     (usesRt),
    .Branch_Taken    (branch),
    .PC_Write        (pcWrite),
    .IFID_Write      (ifidWrite),
    .IDEX_Write      (idexWrite),
    .IFID_Flush      (ifidFlush),
    .IDEX_Flush      (idexFlush),
    .IDEX_Bubble     (idexBubble),
    .EXMEM_Bubble    (exmemBubble),
    .MDU_Start       (mduStart),
    .MDU_Busy        (mduBusy),
    .Stall_Count     (stallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle (after negedge) and settle before checking.
  task automatic drive(input logic r, input logic mr, input logic mdu, input logic [4:0] xrt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic br);
    @(negedge clk);
    rst = r; memRead = mr; mduOp = mdu; exRt = xrt;
    idRs = rs; idRt = rt; usesRt = ur; branch = br;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; memRead = 1'b0; mduOp = 1'b0; exRt = '0;
    idRs = '0; idRt = '0; usesRt = 1'b0; branch = 1'b0;

    // Reset outputs
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("rst_pcwrite", 16'(pcWrite), 16'd0);
    chk("rst_idexwrite", 16'(idexWrite), 16'd0);
    chk("rst_ifidflush", 16'(ifidFlush), 16'd1);
    chk("rst_exmembubble", 16'(exmemBubble), 16'd1);
    chk("rst_busy", 16'(mduBusy), 16'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Idle after reset: defaults, no counted stalls
    idle();
    chk("idle_pcwrite", 16'(pcWrite), 16'd1);
    chk("idle_flush", 16'(ifidFlush), 16'd0);
    chk("idle_stallcnt", stallCount, 16'd0);

    // Load-use on Rs
    drive(1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    chk("lu_pcwrite", 16'(pcWrite), 16'd0);
    chk("lu_ifidwrite", 16'(ifidWrite), 16'd0);
    chk("lu_idexwrite", 16'(idexWrite), 16'd1);
    chk("lu_bubble", 16'(idexBubble), 16'd1);
    idle();
    chk("lu_release", 16'(pcWrite), 16'd1);
    chk("lu_stallcnt", stallCount, 16'd1);

    // $zero load and unused Rt never stall
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("zero_pcwrite", 16'(pcWrite), 16'd1);
    drive(1'b0, 1'b1, 1'b0, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
    chk("nouse_rt_pcwrite", 16'(pcWrite), 16'd1);
    drive(1'b0, 1'b1, 1'b0, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
    chk("use_rt_pcwrite", 16'(pcWrite), 16'd0);
    idle();
    chk("use_rt_stallcnt", stallCount, 16'd2);

    // Branch overrides a simultaneous load-use
    drive(1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
    chk("br_ifidflush", 16'(ifidFlush), 16'd1);
    chk("br_idexflush", 16'(idexFlush), 16'd1);
    chk("br_pcwrite", 16'(pcWrite), 16'd1);
    chk("br_bubble", 16'(idexBubble), 16'd0);
    idle();
    chk("br_stallcnt", stallCount, 16'd2);

    // MDU launch and wait, branch ignored while waiting
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("mdu_start", 16'(mduStart), 16'd1);
    chk("mdu_start_pc", 16'(pcWrite), 16'd0);
    chk("mdu_start_exmem", 16'(exmemBubble), 16'd1);
    chk("mdu_start_busy", 16'(mduBusy), 16'd0);
    drive(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
    chk("mdu_w1_busy", 16'(mduBusy), 16'd1);
    chk("mdu_w1_start", 16'(mduStart), 16'd0);
    chk("mdu_w1_pc", 16'(pcWrite), 16'd0);
    chk("mdu_w1_noflush", 16'(ifidFlush), 16'd0);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("mdu_w2_busy", 16'(mduBusy), 16'd1);
    chk("mdu_w2_pc", 16'(pcWrite), 16'd0);
    chk("mdu_w2_start", 16'(mduStart), 16'd0);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("mdu_w3_busy", 16'(mduBusy), 16'd1);
    chk("mdu_w3_pc", 16'(pcWrite), 16'd1);
    chk("mdu_w3_exmem", 16'(exmemBubble), 16'd0);
    chk("mdu_w3_start", 16'(mduStart), 16'd0);
    idle();
    chk("mdu_done_busy", 16'(mduBusy), 16'd0);
    chk("mdu_stallcnt", stallCount, 16'd5);

    // Reset in MDU_WAIT at cnt=2 abandons the operation
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("rmdu_busy_pre", 16'(mduBusy), 16'd1);
    drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("rmdu_busy", 16'(mduBusy), 16'd0);
    chk("rmdu_start", 16'(mduStart), 16'd0);
    chk("rmdu_pcwrite", 16'(pcWrite), 16'd0);
    idle();
    chk("rmdu_after_busy", 16'(mduBusy), 16'd0);
    chk("rmdu_after_pc", 16'(pcWrite), 16'd1);
    chk("rmdu_after_start", 16'(mduStart), 16'd0);
    chk("rmdu_stallcnt", stallCount, 16'd0);

    // Stall counter saturation under a sustained load-use
    for (int i = 0; i < 65540; i++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
    end
    chk("sat_stallcnt", stallCount, 16'hFFFF);
    idle();
    chk("sat_hold", stallCount, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
